scroll_word_7seg: RTL
=====================

Name: scroll_word_7seg

Overview:
- Parametrised successor to the fixed 3-display word rotator: holds a MSG_LEN-character message of 2-bit codes and shows a NUM_DISP-wide window of it on active-low 7-segment displays.
- Window position advances on an internal divided tick: rotate left, rotate right, or bounce.
- Sits between board switches/keys and the HEX outputs of the lab top level.

Parameters:
NUM_DISP, 3, number of 7-seg displays driven; must be >= 1
MSG_LEN, 4, message length in characters; must be >= NUM_DISP
TICK_DIV, 50000000, clock cycles per advance step; must be >= 1 (1 = every cycle)

Ports:
CLOCK_50  in  1  system clock, all state on rising edge
KEY0  in  1  reset, asynchronous, active-low
load  in  1  sync pulse; captures msg_in
msg_in  in  2*MSG_LEN  char k at bits [2k+1:2k]; char 0 leftmost
mode  in  2  00 hold, 01 rotate left, 10 rotate right, 11 bounce
HEX  out  7*NUM_DISP  display d at [7d+6:7d]; d=0 rightmost (HEX0); bit 0=seg a ... bit 6=seg g, active-low
offset  out  max(1,$clog2(MSG_LEN))  current window start index
dir  out  1  bounce direction, 0=increasing, 1=decreasing
tick  out  1  one-cycle pulse at each divider terminal count

Behaviour:
- Character codes: 00 'd' = 7'b0100001; 01 'E' = 7'b0000110; 10 '1' = 7'b1111001; 11 blank = 7'b1111111.
- Reset (KEY0=0, asynchronous):
  - message register all 11 (blank); offset=0, dir=0, divider count=0, tick=0.
  - HEX all ones.
- Display d shows message char (offset + NUM_DISP-1-d) mod MSG_LEN.
- HEX is a combinational decode of the registered message/offset; it changes in the same cycle as the register edge. No extra latency.
- Divider: free-running 0..TICK_DIV-1 in all modes. tick=1 for one cycle when count==TICK_DIV-1, then count wraps to 0.
- Advance is taken on a cycle with tick=1 and load=0:
  - 00 hold: no change.
  - 01: offset <= (offset+1) mod MSG_LEN. Text moves left.
  - 10: offset <= (offset==0) ? MSG_LEN-1 : offset-1.
  - 11 bounce, MAXOFF = MSG_LEN-NUM_DISP:
    - dir=0: if offset<MAXOFF then offset+1; else dir<=1 and offset<=MAXOFF-1 (stays at 0 if MAXOFF=0).
    - dir=1: if offset>0 then offset-1; else dir<=0 and offset<=min(1,MAXOFF).
    - offset>MAXOFF on entering bounce (left over from rotation): the next advance sets offset=MAXOFF, dir=1.
- load=1: message <= msg_in; offset <= 0; dir <= 0; divider count <= 0.
  - load takes priority over a coincident tick; that advance is discarded.
  - tick still pulses on that cycle if the count was terminal.
- mode changes take effect at the next advance. dir is retained across mode changes and reset only by reset/load.
- MSG_LEN==NUM_DISP: rotation still wraps; bounce holds offset 0 with dir toggling each advance.

Optional Feature:
MANUAL_STEP_EN
- Defined: adds input port step (1 bit, sync pulse). An advance occurs on any cycle with (tick | step) and load=0. At most one advance per cycle; step does not touch the divider.
- Undefined: no step port; advances come from tick only.

Test Plan (NUM_DISP=3, MSG_LEN=4, TICK_DIV=4):
- Reset then idle, mode=00 -> HEX=21'h1FFFFF, offset=0, tick pulses every 4th cycle, HEX unchanged.
- load with msg_in=8'hE4, mode=00 -> HEX={0100001,0000110,1111001} ('d','E','1'), offset=0.
- mode=01 after load -> offset sequence 1,2,3,0 at each tick; offset=1 shows {E,1,blank}.
- mode=10 from offset 0 -> first tick gives offset=3, HEX={blank,d,E}.
- mode=11 from offset 3 -> next tick offset=1, dir=1. Following ticks: 0 (dir 1), 1 (dir 0), 0 (dir 1).
- load asserted on a tick cycle while mode=01 -> offset=0, no advance that cycle. Next advance occurs 4 cycles later. KEY0 low mid-scroll -> immediate blank HEX and offset=0 without waiting for a clock edge.

Source files
------------

// File: rtl/scroll_word_7seg.sv
// scroll_word_7seg: shows a NUM_DISP-wide window of a MSG_LEN-character message
// on active-low 7-segment displays.
// The window start index advances on an internal divided tick. Each advance can
// hold, rotate left, rotate right or bounce.
//
// Ports:
//   CLOCK_50  system clock, all state on the rising edge
//   KEY0      asynchronous active-low reset
//   load      sync pulse, captures msg_in and restarts offset/dir/divider
//   msg_in    message, char k at [2k+1:2k], char 0 leftmost
//   mode      00 hold, 01 rotate left, 10 rotate right, 11 bounce
//   step      (MANUAL_STEP_EN only) sync pulse forcing an advance
//   HEX       display d at [7d+6:7d], d=0 rightmost, bit 0 = seg a, active-low
//   offset    current window start index
//   dir       bounce direction, 0 increasing, 1 decreasing
//   tick      one-cycle pulse at divider terminal count
//
// Optional feature macro: MANUAL_STEP_EN (adds the step input).
module scroll_word_7seg #(
    parameter int unsigned NUM_DISP = 3,
    parameter int unsigned MSG_LEN  = 4,
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic                                             CLOCK_50,
    input  logic                                             KEY0,
    input  logic                                             load,
    input  logic [2*MSG_LEN-1:0]                             msg_in,
    input  logic [1:0]                                       mode,
`ifdef MANUAL_STEP_EN
    input  logic                                             step,
`endif
    output logic [7*NUM_DISP-1:0]                            HEX,
    output logic [((MSG_LEN > 1) ? $clog2(MSG_LEN) : 1)-1:0] offset,
    output logic                                             dir,
    output logic                                             tick
);

    localparam int unsigned OW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [OW-1:0] MAX_OFF  = OW'(MSG_LEN - NUM_DISP);
    localparam logic [OW-1:0] LAST_OFF = OW'(MSG_LEN - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [2*MSG_LEN-1:0] msg_q, msg_d;
    logic [OW-1:0]        offset_q, offset_d;
    logic                 dir_q, dir_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 advance;

    function automatic logic [6:0] seg_decode(input logic [1:0] code);
        logic [6:0] s;
        unique case (code)
            2'b00:   s = 7'b0100001; // d
            2'b01:   s = 7'b0000110; // E
            2'b10:   s = 7'b1111001; // 1
            default: s = 7'b1111111; // blank
        endcase
        return s;
    endfunction

    // Message index shown on display d (d=0 is the rightmost display).
    function automatic int unsigned char_idx(input logic [OW-1:0] off, input int unsigned d);
        return (32'(off) + NUM_DISP - 1 - d) % MSG_LEN;
    endfunction

    assign tick = (cnt_q == CNT_LAST);

`ifdef MANUAL_STEP_EN
    assign advance = (tick | step) & ~load;
`else
    assign advance = tick & ~load;
`endif

    always_comb begin
        cnt_d = (load || tick) ? '0 : cnt_q + CW'(1);
    end

    always_comb begin
        msg_d    = msg_q;
        offset_d = offset_q;
        dir_d    = dir_q;
        if (load) begin
            msg_d    = msg_in;
            offset_d = '0;
            dir_d    = 1'b0;
        end else if (advance) begin
            unique case (mode)
                2'b01: offset_d = (offset_q == LAST_OFF) ? '0 : offset_q + OW'(1);
                2'b10: offset_d = (offset_q == '0) ? LAST_OFF : offset_q - OW'(1);
                2'b11: begin
                    if (offset_q > MAX_OFF) begin
                        // Left over from a rotation: snap to the far edge and head back.
                        offset_d = MAX_OFF;
                        dir_d    = 1'b1;
                    end else if (!dir_q) begin
                        if (offset_q < MAX_OFF) begin
                            offset_d = offset_q + OW'(1);
                        end else begin
                            dir_d    = 1'b1;
                            offset_d = (MAX_OFF != '0) ? MAX_OFF - OW'(1) : '0;
                        end
                    end else begin
                        if (offset_q != '0) begin
                            offset_d = offset_q - OW'(1);
                        end else begin
                            dir_d    = 1'b0;
                            offset_d = (MAX_OFF != '0) ? OW'(1) : '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            msg_q    <= '1;
            offset_q <= '0;
            dir_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            msg_q    <= msg_d;
            offset_q <= offset_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
        end
    end

    // Pure decode of registered state, so HEX follows the register edge directly.
    always_comb begin
        HEX = '1;
        for (int d = 0; d < NUM_DISP; d++) begin
            HEX[7*d +: 7] = seg_decode(msg_q[2*char_idx(offset_q, d) +: 2]);
        end
    end

    assign offset = offset_q;
    assign dir    = dir_q;

endmodule
